// File: rtl/priority_select_pkg.sv
// Shared types and limits for the priority_select_rr selector.
package priority_select_pkg;

  typedef enum logic {MODE_FIXED = 1'b0, MODE_RR = 1'b1} mode_t;

  localparam int MAX_CH = 32;

endpackage

// File: rtl/priority_arb_core.sv
// Combinational arbiter: fixed-priority or round-robin winner selection.
// The request vector is duplicated to 2*N_CH bits. Only the positions at or
// above the pointer are kept, so the first set bit is the first requester in
// circular order starting at ptr. Fixed mode is the same search with ptr = 0.
module priority_arb_core
  import priority_select_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int IDX_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req_i,
  input  logic [IDX_W-1:0] ptr_i,
  input  mode_t            mode_i,
  output logic [N_CH-1:0]  gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic [IDX_W-1:0]  ptr_eff;
  logic [2*N_CH-1:0] dbl_req;

  assign ptr_eff = (mode_i == MODE_RR) ? ptr_i : '0;
  assign dbl_req = {req_i, req_i};
  assign any_o   = |req_i;

  // Masked double-width search for the lowest set bit at or above ptr_eff.
  always_comb begin
    logic found;
    found = 1'b0;
    idx_o = '0;
    for (int j = 0; j < 2*N_CH; j++) begin
      if (!found && dbl_req[j] && (j >= int'(ptr_eff))) begin
        found = 1'b1;
        idx_o = (j >= N_CH) ? IDX_W'(j - N_CH) : IDX_W'(j);
      end
    end
  end

  // Decode the winning index to one-hot; the result is all zero when nothing is requested.
  always_comb begin
    gnt_o = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (any_o && (idx_o == IDX_W'(k))) gnt_o[k] = 1'b1;
    end
  end

endmodule

// File: rtl/priority_select_rr.sv
// Registered N-channel priority selector with a valid/ready output stage.
// It supports fixed-priority or round-robin arbitration, and it reports the grant.
module priority_select_rr
  import priority_select_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int W     = 8,
  parameter int IDX_W = $clog2(N_CH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_mode,
  input  logic [N_CH-1:0]   i_ctrl,
  input  logic [N_CH*W-1:0] i_in,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [W-1:0]      o_data,
  output logic [N_CH-1:0]   o_grant,
  output logic [IDX_W-1:0]  o_grant_idx
);

  generate
    if (N_CH < 2 || N_CH > MAX_CH) begin : g_bad_nch
      $error("priority_select_rr: N_CH out of range 2..MAX_CH");
    end
    if (W < 1) begin : g_bad_w
      $error("priority_select_rr: W must be >= 1");
    end
  endgenerate

  logic              valid_q, valid_d;
  logic [W-1:0]      data_q, data_d;
  logic [N_CH-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;

  logic [N_CH-1:0]   arb_gnt;
  logic [IDX_W-1:0]  arb_idx;
  logic              arb_any;
  logic [W-1:0]      data_sel;
  logic              load;
  mode_t             mode;

  assign mode = mode_t'(i_mode);
  assign load = !valid_q || i_ready;

  priority_arb_core #(.N_CH(N_CH), .IDX_W(IDX_W)) u_arb (
    .req_i  (i_ctrl),
    .ptr_i  (ptr_q),
    .mode_i (mode),
    .gnt_o  (arb_gnt),
    .idx_o  (arb_idx),
    .any_o  (arb_any)
  );

  // One-hot AND-OR mux of the winning channel's data.
  always_comb begin
    data_sel = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (arb_gnt[k]) data_sel = data_sel | i_in[k*W +: W];
    end
  end

  // Next state. A stall holds everything. An idle load drops valid and keeps data and idx.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    if (load) begin
      if (arb_any) begin
        valid_d = 1'b1;
        data_d  = data_sel;
        grant_d = arb_gnt;
        idx_d   = arb_idx;
        if (mode == MODE_RR)
          ptr_d = (arb_idx == IDX_W'(N_CH-1)) ? '0 : arb_idx + 1'b1;
      end else begin
        valid_d = 1'b0;
        grant_d = '0;
      end
    end
  end

  // Output register and round-robin pointer, with a synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

  assign o_valid     = valid_q;
  assign o_data      = data_q;
  assign o_grant     = grant_q;
  assign o_grant_idx = idx_q;

endmodule

// File: tb/tb_priority_select_rr.sv
// Directed bench for priority_select_rr (N_CH=4, W=8) with hand-computed expectations.
module tb_priority_select_rr;

  localparam int N_CH  = 4;
  localparam int W     = 8;
  localparam int IDX_W = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              mode;
  logic [N_CH-1:0]   ctrl;
  logic [N_CH*W-1:0] din;
  logic              ready;
  logic              valid;
  logic [W-1:0]      data;
  logic [N_CH-1:0]   grant;
  logic [IDX_W-1:0]  gidx;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  priority_select_rr #(.N_CH(N_CH), .W(W)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_mode      (mode),
    .i_ctrl      (ctrl),
    .i_in        (din),
    .i_ready     (ready),
    .o_valid     (valid),
    .o_data      (data),
    .o_grant     (grant),
    .o_grant_idx (gidx)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d,
                         input logic [3:0] g, input logic [1:0] ix);
    chk({tag, ".valid"}, 32'(valid), 32'(v));
    chk({tag, ".data"},  32'(data),  32'(d));
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".idx"},   32'(gidx),  32'(ix));
  endtask

  initial begin
    int rr_exp [6];
    int rr2_exp [3];
    rr_exp  = '{0, 1, 2, 3, 0, 1};
    rr2_exp = '{3, 0, 3};

    rst_n = 1'b0; mode = 1'b0; ctrl = 4'b1111; ready = 1'b1;
    din   = {8'h44, 8'h33, 8'h22, 8'h11};
    #2;

    // Reset for two cycles while every channel requests.
    step(); step();
    chk_out("reset", 1'b0, 8'h00, 4'b0000, 2'd0);

    // Release the reset with no requests: outputs stay unchanged.
    rst_n = 1'b1; ctrl = 4'b0000;
    step();
    chk_out("idle_after_reset", 1'b0, 8'h00, 4'b0000, 2'd0);

    // Fixed priority: the lowest set bit of 1010 is channel 1.
    ctrl = 4'b1010;
    step();
    chk_out("fixed_1010", 1'b1, 8'h22, 4'b0010, 2'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fixed_hold.idx", 32'(gidx), 32'd1);
    end

    // Round robin with all channels requesting, starting from ptr = 0.
    mode = 1'b1; ctrl = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("rr_1111[%0d].idx", i), 32'(gidx), 32'(rr_exp[i]));
    end
    // ptr = 2 at this point, and the request pattern is 1001.
    ctrl = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rr_1001[%0d].idx", i), 32'(gidx), 32'(rr2_exp[i]));
    end
    // ptr = 0 here.

    // Backpressure: grant ch2 (ptr becomes 3), then stall while the requests change.
    ctrl = 4'b0100;
    step();
    chk_out("bp_grant2", 1'b1, 8'h33, 4'b0100, 2'd2);
    ready = 1'b0; ctrl = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out($sformatf("bp_stall[%0d]", i), 1'b1, 8'h33, 4'b0100, 2'd2);
    end
    // Stalled with all channels requesting. If the stall left ptr at 3, channel 3 wins on release.
    ctrl = 4'b1111;
    step();
    chk_out("bp_stall_all", 1'b1, 8'h33, 4'b0100, 2'd2);
    ready = 1'b1;
    step();
    chk_out("bp_release_ptr", 1'b1, 8'h44, 4'b1000, 2'd3);
    // ptr = 0. Channel 0 alone wins.
    ctrl = 4'b0001;
    step();
    chk_out("bp_release_ch0", 1'b1, 8'h11, 4'b0001, 2'd0);
    // ptr = 1.

    // Idle hold after a grant of ch3.
    ctrl = 4'b1000;
    step();
    chk_out("grant_ch3", 1'b1, 8'h44, 4'b1000, 2'd3);
    ctrl = 4'b0000;
    step();
    chk_out("idle_hold", 1'b0, 8'h44, 4'b0000, 2'd3);
    // ptr = 0 after the ch3 grant. An idle load does not move it.

    // Idle while stalled is a load because valid=0, so the output stays idle.
    ready = 1'b0;
    step();
    chk_out("idle_noready", 1'b0, 8'h44, 4'b0000, 2'd3);
    ready = 1'b1;

    // Mode switch: an RR grant of ch1 leaves ptr = 2.
    ctrl = 4'b0010;
    step();
    chk("rr_ch1.idx", 32'(gidx), 32'd1);
    mode = 1'b0; ctrl = 4'b0001;
    step();
    chk_out("fixed_ch0_a", 1'b1, 8'h11, 4'b0001, 2'd0);
    step();
    chk_out("fixed_ch0_b", 1'b1, 8'h11, 4'b0001, 2'd0);
    // Fixed mode with all requests picks ch0, independent of ptr.
    ctrl = 4'b1111;
    step();
    chk("fixed_1111.idx", 32'(gidx), 32'd0);
    mode = 1'b1;
    step();
    chk_out("rr_resume", 1'b1, 8'h33, 4'b0100, 2'd2);
    // ptr = 3, and valid = 1.

    // Reset mid-operation drops the held sample and clears ptr.
    rst_n = 1'b0;
    step();
    chk_out("reset_mid", 1'b0, 8'h00, 4'b0000, 2'd0);
    rst_n = 1'b1;
    step();
    chk_out("rr_after_reset", 1'b1, 8'h11, 4'b0001, 2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/priority_select_rr.md
Name: priority_select_rr

Overview:
- Registered N-channel, W-bit priority selector. Successor to the 4-channel, 1-bit registered decision-tree selector.
- Adds:
  - parametrised channel count and data width;
  - run-time choice of fixed-priority or round-robin arbitration;
  - a valid/ready output stage with backpressure;
  - grant reporting.
- Sits between multiple request sources and a single downstream consumer in datapath and control muxing.

Parameters:
- N_CH, 4, number of input channels; legal range 2..32, need not be a power of two.
- W, 8, data width per channel; W >= 1.
- IDX_W, $clog2(N_CH), width of the grant index. Derived; not overridden.

Ports:
- i_clk  in  1  clock; all logic is posedge.
- i_rst_n  in  1  synchronous, active-low reset.
- i_mode  in  1  arbitration mode: 0 = fixed priority, 1 = round robin.
- i_ctrl  in  N_CH  per-channel select request; bit k requests channel k.
- i_in  in  N_CH x W  packed per-channel data; channel k occupies bits [k*W +: W].
- i_ready  in  1  downstream accepts o_data this cycle.
- o_valid  out  1  o_data holds a granted sample.
- o_data  out  W  registered data of the winning channel.
- o_grant  out  N_CH  one-hot winner; zero when o_valid = 0.
- o_grant_idx  out  IDX_W  binary index of the last winner.

Behaviour:
- Reset: sampled on the i_clk edge while i_rst_n = 0, and overrides all other activity. On reset:
  - o_valid = 0, o_data = 0, o_grant = 0, o_grant_idx = 0;
  - round-robin pointer ptr = 0.
- Reset mid-transfer discards the held sample with no acceptance.
- Load condition: load = !o_valid || i_ready. The output register is updated only when load = 1.
- Stall (load = 0): all outputs and ptr hold. i_ctrl, i_in and i_mode are ignored; a stalled sample is never replaced.
- Load with no request (i_ctrl = 0):
  - o_valid <= 0 and o_grant <= 0;
  - o_data and o_grant_idx hold their last values, preserving the hold-last-value behaviour of the previous generation.
- Load with at least one request:
  - winner k selected combinationally;
  - o_data <= i_in[k], o_valid <= 1, o_grant <= one-hot(k), o_grant_idx <= k.
- Latency: one cycle from request to o_valid.
- Throughput: one grant per cycle while i_ready = 1.
- Fixed mode (i_mode = 0):
  - k = lowest set index of i_ctrl;
  - ptr is not modified.
- Round-robin mode (i_mode = 1):
  - k = first set index searching ptr, ptr+1, ..., N_CH-1, 0, ..., ptr-1;
  - on a load with a grant, ptr <= (k == N_CH-1) ? 0 : k+1;
  - no ptr update on loads without a grant.
- Mode switch: i_mode is sampled on the load cycle only. ptr retains its value across fixed-mode periods, and round robin resumes from the stored ptr.
- Single requester: wins in both modes regardless of ptr.
- Request withdrawal: i_ctrl need not be held. A request dropped during a stall is simply not seen; there is no request memory.
- Simultaneous i_ready = 1 with new requests: the held sample is accepted and the new winner is loaded in the same edge (back-to-back).
- No combinational path from any input to any output; all outputs are registered.

Decomposition:
- Shared package priority_select_pkg:
  - typedef enum logic {MODE_FIXED = 1'b0, MODE_RR = 1'b1} mode_t;
  - localparam MAX_CH = 32 for parameter checks.
- Sub-module priority_arb_core: purely combinational.
  - Inputs: request vector, ptr, mode.
  - Outputs: one-hot grant, binary index, any-request flag.
  - Implementation: double-width masked priority encoder.
  - Top module holds the output register, handshake and ptr.
- Elaboration check: N_CH in 2..MAX_CH, W >= 1.

Test Plan:
- Reset then idle: rst_n low 2 cycles with i_ctrl = 4'b1111 → o_valid = 0, o_data = 0, o_grant = 0. Release with i_ctrl = 0 → outputs unchanged.
- Fixed priority, N_CH = 4, W = 8:
  - i_in = {8'h44, 8'h33, 8'h22, 8'h11}, i_ctrl = 4'b1010, i_ready = 1 → next cycle o_data = 8'h22, o_grant = 4'b0010, o_grant_idx = 1.
  - Hold i_ctrl = 4'b1010 for 3 cycles → o_grant_idx = 1 every cycle.
- Round robin: i_mode = 1, i_ctrl = 4'b1111 held, i_ready = 1 for 6 cycles → o_grant_idx = 0, 1, 2, 3, 0, 1.
  - Then i_ctrl = 4'b1001 → o_grant_idx = 3, 0, 3.
- Backpressure:
  - grant ch2 with i_ready = 0 for 3 cycles while i_ctrl changes to 4'b0001 → o_data stays 8'h33, o_valid = 1, ptr unchanged;
  - i_ready = 1 → next cycle o_data = 8'h11.
- Idle hold: after grant of ch3 (8'h44), i_ctrl = 0 with i_ready = 1 → o_valid = 0, o_grant = 0, o_data stays 8'h44, o_grant_idx = 3.
- Mode switch and reset mid-operation:
  - RR leaves ptr = 2; switch to fixed, grant ch0 twice; return to RR with i_ctrl = 4'b1111 → o_grant_idx = 2.
  - Assert rst_n = 0 while o_valid = 1 → next cycle o_valid = 0, and the next RR grant with i_ctrl = 4'b1111 is ch0.
